// File: rtl/if_prefetch_queue_if.sv
// Port bundle for the instruction prefetch queue: the IF-stage side (redirect/take/head outputs)
// and the instruction memory req/ack side.
interface if_prefetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        take;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] pcplus4_o;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  redirect, redirect_pc, take, mem_ack, mem_rdata,
    output valid_o, inst_o, pc_o, pcplus4_o, mem_req, mem_addr
  );

  modport master (
    output redirect, redirect_pc, take, mem_ack, mem_rdata,
    input  valid_o, inst_o, pc_o, pcplus4_o, mem_req, mem_addr
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words over a single-outstanding req/ack port into a
// DEPTH-entry FIFO and presents the head {inst, pc, pc+4} to IF; redirect flushes and restarts fetch.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  if_prefetch_queue_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0]   r_mem_addr, w_mem_addr_nxt;
  logic [31:0]   w_fetch_pc_inc;
  logic [31:0]   r_inst [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          w_push, w_pop;

  // Redirect overrides both push and pop: the ack'd word and the head are discarded by the flush.
  assign w_pop          = bus.take && (r_count != '0) && !bus.redirect;
  assign w_push         = (r_state == S_REQ) && bus.mem_ack && !bus.redirect;
  assign w_fetch_pc_inc = r_fetch_pc + 32'd4;

  always_comb begin
    w_count_nxt = r_count;
    if (bus.redirect) w_count_nxt = '0;
    else              w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  end

  // Space test uses the post-update count, so at most DEPTH entries plus in-flight words ever exist.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_mem_addr_nxt = r_mem_addr;
    case (r_state)
      S_IDLE: begin
        if (bus.redirect) begin
          w_fetch_pc_nxt = bus.redirect_pc;
          w_mem_addr_nxt = bus.redirect_pc;
          w_state_nxt    = S_REQ;
        end else if (w_count_nxt < DEPTH_C) begin
          w_mem_addr_nxt = r_fetch_pc;
          w_state_nxt    = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.redirect) begin
          w_fetch_pc_nxt = bus.redirect_pc;
          if (bus.mem_ack) begin
            w_mem_addr_nxt = bus.redirect_pc;
            w_state_nxt    = S_REQ;
          end else begin
            w_state_nxt    = S_DRAIN;
          end
        end else if (bus.mem_ack) begin
          w_fetch_pc_nxt = w_fetch_pc_inc;
          if (w_count_nxt < DEPTH_C) begin
            w_mem_addr_nxt = w_fetch_pc_inc;
            w_state_nxt    = S_REQ;
          end else begin
            w_state_nxt    = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (bus.redirect) w_fetch_pc_nxt = bus.redirect_pc;
        if (bus.mem_ack)  w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_inst[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      if (bus.redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_push) begin
          r_inst[r_wr_ptr] <= bus.mem_rdata;
          r_pc[r_wr_ptr]   <= r_fetch_pc;
          r_wr_ptr         <= r_wr_ptr + AW'(1);
        end
      end
    end
  end

  assign bus.mem_req   = (r_state != S_IDLE);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.valid_o   = (r_count != '0);
  assign bus.inst_o    = r_inst[r_rd_ptr];
  assign bus.pc_o      = r_pc[r_rd_ptr];
  assign bus.pcplus4_o = r_pc[r_rd_ptr] + 32'd4;

endmodule
